// File: rtl/lcd_text_pkg.sv
// Shared constants for the LCD text composer: opcodes, special characters,
// display geometry and the FSM state encoding.
package lcd_text_pkg;

  localparam int NUM_CHARS = 32;
  localparam int LINE_LEN  = 16;

  localparam logic [1:0] OP_PUT    = 2'b00;
  localparam logic [1:0] OP_SETPOS = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_COMMIT = 2'b11;

  localparam logic [7:0] CH_SPACE   = 8'h20;
  localparam logic [7:0] CH_NEWLINE = 8'h0A;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/lcd_text_composer.sv
// Composes text in a private working buffer and publishes it to the LCD
// driver as a whole frame only when the producer commits.
module lcd_text_composer
  import lcd_text_pkg::*;
#(
  parameter int NUM_CHARS = lcd_text_pkg::NUM_CHARS,
  parameter int LINE_LEN  = lcd_text_pkg::LINE_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [1:0]             wr_op,
  input  logic [7:0]             wr_data,
  output logic [8*NUM_CHARS:0]   chars,
  output logic                   frame_stb,
  output logic [4:0]             cursor
);

  logic [7:0]             working [NUM_CHARS];
  logic [8*NUM_CHARS-1:0] chars_q;
  logic [0:0]             state;
  logic [4:0]             fill;
  logic [4:0]             cursor_q;
  logic                   frame_stb_q;
  logic                   accept;

  // Ready is gated by rst so it reads 0 throughout reset and 1 as soon as it drops.
  assign wr_ready  = ~rst & (state == ST_IDLE);
  assign accept    = wr_valid & wr_ready;
  assign chars     = {1'b0, chars_q};
  assign frame_stb = frame_stb_q;
  assign cursor    = cursor_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CHARS; k++) working[k] <= CH_SPACE;
      chars_q     <= {NUM_CHARS{CH_SPACE}};
      cursor_q    <= '0;
      state       <= ST_IDLE;
      fill        <= '0;
      frame_stb_q <= 1'b0;
    end else begin
      frame_stb_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (wr_op)
              OP_PUT: begin
                // Newline jumps to the start of the other line without writing a cell.
                if (wr_data == CH_NEWLINE) begin
                  cursor_q <= (cursor_q < 5'(LINE_LEN)) ? 5'(LINE_LEN) : 5'd0;
                end else begin
                  working[cursor_q] <= wr_data;
                  cursor_q          <= cursor_q + 5'd1;
                end
              end
              OP_SETPOS: cursor_q <= wr_data[4:0];
              OP_CLEAR: begin
                state <= ST_CLEAR;
                fill  <= '0;
              end
              default: begin
                for (int k = 0; k < NUM_CHARS; k++)
                  chars_q[8*NUM_CHARS-1-8*k -: 8] <= working[k];
                frame_stb_q <= 1'b1;
              end
            endcase
          end
        end
        default: begin
          working[fill] <= CH_SPACE;
          fill          <= fill + 5'd1;
          if (fill == 5'(NUM_CHARS - 1)) begin
            state    <= ST_IDLE;
            cursor_q <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_composer.sv
// Directed self-checking bench for lcd_text_composer: operations are driven and
// outputs sampled on the falling clock edge.
module tb_lcd_text_composer;
  import lcd_text_pkg::*;

  logic         clk;
  logic         rst;
  logic         wr_valid;
  logic         wr_ready;
  logic [1:0]   wr_op;
  logic [7:0]   wr_data;
  logic [256:0] chars;
  logic         frame_stb;
  logic [4:0]   cursor;

  int vectors;
  int miscompares;
  int stb_count;

  localparam logic [255:0] ALL_SPACE = {32{8'h20}};
  localparam logic [255:0] ALL_X     = {32{8'h58}};

  logic [255:0] exp_frame;
  logic [255:0] saved_frame;
  logic [4:0]   m_cur;
  logic [1:0]   r_op;
  logic [7:0]   r_data;
  int           low_cycles;
  int           stb_before;

  lcd_text_composer dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_op     (wr_op),
    .wr_data   (wr_data),
    .chars     (chars),
    .frame_stb (frame_stb),
    .cursor    (cursor)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (frame_stb === 1'b1) stb_count++;

  task automatic check_output(input string tag, input logic [256:0] obs, input logic [256:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offers one operation and returns on the falling edge after the transfer.
  task automatic apply_stimulus(input logic [1:0] op, input logic [7:0] data);
    int waited;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_op    = op;
    wr_data  = data;
    waited   = 0;
    while (wr_ready !== 1'b1 && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 100) begin
      check_output("handshake_timeout", 257'(waited), 257'd0);
      wr_valid = 1'b0;
    end else begin
      @(negedge clk);
      wr_valid = 1'b0;
    end
  endtask

  function automatic logic [255:0] put_cell(input logic [255:0] f, input int k, input logic [7:0] v);
    logic [255:0] r;
    r = f;
    r[255-8*k -: 8] = v;
    return r;
  endfunction

  initial begin
    vectors = 0; miscompares = 0; stb_count = 0;
    rst = 1'b1; wr_valid = 1'b0; wr_op = 2'b00; wr_data = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    check_output("reset_chars", chars, {1'b0, ALL_SPACE});
    check_output("reset_ready", 257'(wr_ready), 257'd0);
    check_output("reset_stb", 257'(frame_stb), 257'd0);
    check_output("reset_cursor", 257'(cursor), 257'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("ready_after_reset", 257'(wr_ready), 257'd1);

    // "HI" then commit
    apply_stimulus(OP_PUT, 8'h48);
    apply_stimulus(OP_PUT, 8'h49);
    check_output("no_commit_yet", chars, {1'b0, ALL_SPACE});
    apply_stimulus(OP_COMMIT, 8'h00);
    exp_frame = put_cell(put_cell(ALL_SPACE, 0, 8'h48), 1, 8'h49);
    check_output("hi_chars", chars, {1'b0, exp_frame});
    check_output("hi_stb_high", 257'(frame_stb), 257'd1);
    check_output("hi_cursor", 257'(cursor), 257'd2);
    @(negedge clk);
    check_output("hi_stb_low", 257'(frame_stb), 257'd0);
    check_output("hi_chars_hold", chars, {1'b0, exp_frame});

    // Wrap from cell 31 to cell 0, upper SETPOS bits ignored
    apply_stimulus(OP_SETPOS, 8'hFF);
    check_output("setpos_31", 257'(cursor), 257'd31);
    apply_stimulus(OP_PUT, 8'h41);
    apply_stimulus(OP_PUT, 8'h42);
    check_output("wrap_cursor", 257'(cursor), 257'd1);
    apply_stimulus(OP_COMMIT, 8'h00);
    exp_frame = put_cell(put_cell(exp_frame, 31, 8'h41), 0, 8'h42);
    check_output("wrap_chars", chars, {1'b0, exp_frame});

    // Newline on each line
    apply_stimulus(OP_SETPOS, 8'hE5);
    check_output("setpos_5", 257'(cursor), 257'd5);
    apply_stimulus(OP_PUT, CH_NEWLINE);
    check_output("newline_line0", 257'(cursor), 257'd16);
    apply_stimulus(OP_PUT, CH_NEWLINE);
    check_output("newline_line1", 257'(cursor), 257'd0);
    apply_stimulus(OP_COMMIT, 8'h00);
    check_output("newline_no_write", chars, {1'b0, exp_frame});

    // Fill with 'X', then clear with wr_valid held
    apply_stimulus(OP_SETPOS, 8'h00);
    for (int i = 0; i < 32; i++) apply_stimulus(OP_PUT, 8'h58);
    check_output("fill_cursor", 257'(cursor), 257'd0);
    apply_stimulus(OP_COMMIT, 8'h00);
    check_output("fill_chars", chars, {1'b0, ALL_X});
    @(negedge clk);
    stb_before = stb_count;
    wr_valid = 1'b1; wr_op = OP_CLEAR; wr_data = 8'h00;
    @(negedge clk);
    low_cycles = 0;
    while (wr_ready !== 1'b1 && low_cycles < 40) begin
      low_cycles++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check_output("clear_ready_low", 257'(low_cycles), 257'd32);
    check_output("clear_chars_hold", chars, {1'b0, ALL_X});
    check_output("clear_no_stb", 257'(stb_count - stb_before), 257'd0);
    check_output("clear_cursor", 257'(cursor), 257'd0);
    apply_stimulus(OP_COMMIT, 8'h00);
    check_output("clear_chars", chars, {1'b0, ALL_SPACE});

    // Reset during a clear
    apply_stimulus(OP_PUT, 8'h51);
    apply_stimulus(OP_COMMIT, 8'h00);
    check_output("pre_abort_chars", chars, {1'b0, put_cell(ALL_SPACE, 0, 8'h51)});
    apply_stimulus(OP_PUT, 8'h52);
    apply_stimulus(OP_CLEAR, 8'h00);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("abort_chars", chars, {1'b0, ALL_SPACE});
    check_output("abort_ready", 257'(wr_ready), 257'd0);
    check_output("abort_cursor", 257'(cursor), 257'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("abort_ready_back", 257'(wr_ready), 257'd1);
    apply_stimulus(OP_COMMIT, 8'h00);
    check_output("abort_working", chars, {1'b0, ALL_SPACE});

    // Random PUT/SETPOS without commit, against a reference model
    @(negedge clk);
    saved_frame = chars[255:0];
    stb_before  = stb_count;
    exp_frame   = ALL_SPACE;
    m_cur       = 5'd0;
    for (int i = 0; i < 1000; i++) begin
      r_op   = ($urandom_range(0, 1) == 0) ? OP_PUT : OP_SETPOS;
      r_data = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) r_data = CH_NEWLINE;
      apply_stimulus(r_op, r_data);
      if (r_op == OP_SETPOS) m_cur = r_data[4:0];
      else if (r_data == CH_NEWLINE) m_cur = (m_cur < 5'd16) ? 5'd16 : 5'd0;
      else begin
        exp_frame = put_cell(exp_frame, int'(m_cur), r_data);
        m_cur = m_cur + 5'd1;
      end
    end
    check_output("random_chars_hold", chars, {1'b0, saved_frame});
    check_output("random_no_stb", 257'(stb_count - stb_before), 257'd0);
    check_output("random_cursor", 257'(cursor), 257'(m_cur));
    apply_stimulus(OP_COMMIT, 8'h00);
    check_output("random_commit", chars, {1'b0, exp_frame});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
